// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO burst read controller: FSM encoding and skid sizing.
package fifo_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_REQ  = 2'd1;
   localparam state_t ST_XFER = 2'd2;

   localparam int unsigned SKID_DEPTH = 2;
   localparam int unsigned SKID_PTR_W = $clog2(SKID_DEPTH);
   localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry skid buffer catching FIFO read data that returns one cycle after the strobe.
module rd_skid_buf
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_W-1:0]     push_data,
   input  logic                  pop,
   output logic [DATA_W-1:0]     pop_data,
   output logic [SKID_CNT_W-1:0] count
);

   logic [DATA_W-1:0]     mem_q [SKID_DEPTH];
   logic [DATA_W-1:0]     mem_d [SKID_DEPTH];
   logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [SKID_CNT_W-1:0] count_q, count_d;

   // Next-state: write at wr_ptr, read at rd_ptr; pointers wrap since depth is a power of two.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
      end
      wr_ptr_d = wr_ptr_q + SKID_PTR_W'(push);
      rd_ptr_d = rd_ptr_q + SKID_PTR_W'(pop);
      count_d  = count_q + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
   end

   // Storage and pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SKID_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// Reads fixed-length (or flushed short) bursts from a FIFO and streams them out valid/ready.
module fifo_burst_rd_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned LVL_W     = 8,
   parameter int unsigned BURST_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_rd_data,
   input  logic              fifo_rd_empty,
   input  logic [LVL_W-1:0]  fifo_rd_water_level,
   input  logic              flush,
   output logic              burst_req,
   output logic [LVL_W-1:0]  burst_len,
   input  logic              burst_ack,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_valid,
   output logic              dout_last,
   input  logic              dout_ready,
   output logic              busy,
   output logic              flush_done
);

   localparam logic [LVL_W-1:0] BURST_LEN_L = LVL_W'(BURST_LEN);

   state_t           state_q, state_d;
   logic [LVL_W-1:0] len_q, len_d;
   logic [LVL_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [LVL_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             flush_pend_q, flush_pend_d;
   logic             flush_done_q, flush_done_d;
   logic             inflight_q, inflight_d;

   logic [SKID_CNT_W-1:0] skid_cnt;
   logic [DATA_W-1:0]     skid_data;
   logic [2:0]            occ_after;
   logic                  pop;
   logic                  rd_en;
   logic                  last_beat;

   rd_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (fifo_rd_data),
      .pop       (pop),
      .pop_data  (skid_data),
      .count     (skid_cnt)
   );

   // Read gating: room must remain for the read in flight plus this one after this cycle's pop.
   always_comb begin
      pop       = !rst && (skid_cnt != '0) && dout_ready;
      occ_after = 3'(skid_cnt) - 3'(pop) + 3'(inflight_q);
      rd_en     = !rst && (state_q == ST_XFER) && (rd_cnt_q < len_q) && !fifo_rd_empty &&
                  (occ_after < 3'(SKID_DEPTH));
      last_beat = (beat_cnt_q == len_q - 1'b1);
   end

   // FSM and counter next-state.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      rd_cnt_d     = rd_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      flush_pend_d = flush_pend_q | flush;
      flush_done_d = 1'b0;
      inflight_d   = rd_en;
      case (state_q)
         ST_IDLE: begin
            // A full burst wins over a pending flush; flush stays pending until the FIFO is empty.
            if (fifo_rd_water_level >= BURST_LEN_L) begin
               len_d   = BURST_LEN_L;
               state_d = ST_REQ;
            end else if (flush_pend_q) begin
               if (fifo_rd_water_level != '0) begin
                  len_d   = fifo_rd_water_level;
                  state_d = ST_REQ;
               end else begin
                  flush_pend_d = 1'b0;
                  flush_done_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (burst_ack) begin
               rd_cnt_d   = '0;
               beat_cnt_d = '0;
               state_d    = ST_XFER;
            end
         end
         ST_XFER: begin
            if (rd_en) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
            if (pop) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (last_beat) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         rd_cnt_q     <= '0;
         beat_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         flush_done_q <= 1'b0;
         inflight_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         rd_cnt_q     <= rd_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         flush_pend_q <= flush_pend_d;
         flush_done_q <= flush_done_d;
         inflight_q   <= inflight_d;
      end
   end

   // Outputs are forced low while reset is held so nothing leaks during the reset cycle.
   always_comb begin
      fifo_rd_en = rd_en;
      burst_req  = !rst && (state_q == ST_REQ);
      burst_len  = rst ? '0 : len_q;
      dout_valid = !rst && (skid_cnt != '0);
      dout_data  = rst ? '0 : skid_data;
      dout_last  = dout_valid && last_beat;
      busy       = !rst && (state_q != ST_IDLE);
      flush_done = !rst && flush_done_q;
   end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Directed bench for fifo_burst_rd_ctrl with a behavioural FIFO and handshake monitor.
module tb_fifo_burst_rd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_rd_en;
   logic [63:0] fifo_rd_data = '0;
   logic        fifo_rd_empty;
   logic [7:0]  fifo_rd_water_level;
   logic        flush;
   logic        burst_req;
   logic [7:0]  burst_len;
   logic        burst_ack;
   logic [63:0] dout_data;
   logic        dout_valid;
   logic        dout_last;
   logic        dout_ready;
   logic        busy;
   logic        flush_done;

   int vectors = 0;
   int miscompares = 0;

   fifo_burst_rd_ctrl #(
      .DATA_W    (64),
      .LVL_W     (8),
      .BURST_LEN (16)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .fifo_rd_en          (fifo_rd_en),
      .fifo_rd_data        (fifo_rd_data),
      .fifo_rd_empty       (fifo_rd_empty),
      .fifo_rd_water_level (fifo_rd_water_level),
      .flush               (flush),
      .burst_req           (burst_req),
      .burst_len           (burst_len),
      .burst_ack           (burst_ack),
      .dout_data           (dout_data),
      .dout_valid          (dout_valid),
      .dout_last           (dout_last),
      .dout_ready          (dout_ready),
      .busy                (busy),
      .flush_done          (flush_done)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: read data appears the cycle after the strobe.
   logic        push_en;
   logic [63:0] push_val;
   logic [63:0] fmem [0:255];
   logic [31:0] wr_p = '0;
   logic [31:0] rd_p = '0;

   always @(posedge clk) begin
      if (push_en) begin
         fmem[wr_p[7:0]] <= push_val;
         wr_p <= wr_p + 1;
      end
      if (fifo_rd_en) begin
         fifo_rd_data <= fmem[rd_p[7:0]];
         rd_p <= rd_p + 1;
      end
   end

   assign fifo_rd_empty       = (wr_p == rd_p);
   assign fifo_rd_water_level = 8'(wr_p - rd_p);

   // Downstream stimulus: ready pattern and delayed ack.
   logic ready_tog;
   logic tog = 1'b1;
   int   ack_delay;
   int   req_cyc = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tog = ~tog;
         if (burst_req) req_cyc = req_cyc + 1;
         else req_cyc = 0;
      end
   end

   assign dout_ready = ready_tog ? tog : 1'b1;
   assign burst_ack  = burst_req && (req_cyc > ack_delay);

   // Monitor sampled on the falling edge.
   logic [63:0] beat_q [$];
   bit          last_q [$];
   int          beat_cyc [$];
   logic [7:0]  len_q [$];
   int  cyc = 0;
   int  req_hi = 0;
   int  len_unstable = 0;
   int  rd_during_req = 0;
   int  issued = 0;
   int  accepted = 0;
   int  overflow = 0;
   int  fd_cnt = 0;
   int  fd_cyc = 0;
   logic       req_prev = 1'b0;
   logic [7:0] len_prev = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (dout_valid && dout_ready) begin
         beat_q.push_back(dout_data);
         last_q.push_back(dout_last);
         beat_cyc.push_back(cyc);
         accepted <= accepted + 1;
      end
      if (burst_req && !req_prev) len_q.push_back(burst_len);
      if (burst_req) begin
         req_hi <= req_hi + 1;
         if (req_prev && (burst_len != len_prev)) len_unstable <= len_unstable + 1;
         if (fifo_rd_en) rd_during_req <= rd_during_req + 1;
      end
      if (fifo_rd_en) issued <= issued + 1;
      if (!rst && ((issued + int'(fifo_rd_en)) - (accepted + int'(dout_valid && dout_ready)) > 2))
         overflow <= overflow + 1;
      if (flush_done) begin
         fd_cnt <= fd_cnt + 1;
         fd_cyc <= cyc;
      end
      req_prev <= burst_req;
      len_prev <= burst_len;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_n(input int n, input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         push_en  = 1'b1;
         push_val = base + 64'(i);
         cycles(1);
      end
      push_en = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
   endtask

   task automatic wait_beats(input int target, input int budget, input string tag);
      for (int k = 0; k < budget && beat_q.size() < target; k++) cycles(1);
      chk({tag, "_done"}, 64'(beat_q.size() >= target), 64'd1);
   endtask

   task automatic check_burst(input string tag, input int b0, input int n,
                              input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_data%0d", tag, i), beat_q[b0 + i], base + 64'(i));
         chk($sformatf("%s_last%0d", tag, i), 64'(last_q[b0 + i]), 64'(i == n - 1));
      end
   endtask

   int b0, l0, fd0, r0, q0, u0, beats_rst, issued_rst;

   initial begin
      rst = 1'b1;
      push_en = 1'b0;
      push_val = '0;
      flush = 1'b0;
      ready_tog = 1'b0;
      ack_delay = 0;
      cycles(3);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("rst_req", 64'(burst_req), 64'd0);
      chk("rst_len", 64'(burst_len), 64'd0);
      chk("rst_valid", 64'(dout_valid), 64'd0);
      chk("rst_last", 64'(dout_last), 64'd0);
      chk("rst_data", dout_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_fdone", 64'(flush_done), 64'd0);
      rst = 1'b0;
      cycles(2);
      chk("idle_busy", 64'(busy), 64'd0);

      // Full 16-beat burst, ready held high.
      b0 = beat_q.size(); l0 = len_q.size();
      push_n(16, 64'd0);
      wait_beats(b0 + 16, 200, "s1");
      cycles(3);
      chk("s1_nreq", 64'(len_q.size() - l0), 64'd1);
      chk("s1_len", 64'(len_q[l0]), 64'd16);
      chk("s1_nbeats", 64'(beat_q.size() - b0), 64'd16);
      check_burst("s1", b0, 16, 64'd0);
      chk("s1_thruput", 64'(beat_cyc[b0 + 15] - beat_cyc[b0]), 64'd15);
      chk("s1_busy", 64'(busy), 64'd0);

      // Five words then flush.
      b0 = beat_q.size(); l0 = len_q.size(); fd0 = fd_cnt;
      push_n(5, 64'd100);
      cycles(4);
      chk("s2_noburst", 64'(busy), 64'd0);
      chk("s2_noreq", 64'(len_q.size() - l0), 64'd0);
      pulse_flush();
      wait_beats(b0 + 5, 100, "s2");
      cycles(4);
      chk("s2_nreq", 64'(len_q.size() - l0), 64'd1);
      chk("s2_len", 64'(len_q[l0]), 64'd5);
      chk("s2_nbeats", 64'(beat_q.size() - b0), 64'd5);
      check_burst("s2", b0, 5, 64'd100);
      chk("s2_fdone_cnt", 64'(fd_cnt - fd0), 64'd1);
      chk("s2_fdone_cyc", 64'(fd_cyc), 64'(beat_cyc[b0 + 4] + 2));

      // Toggling ready.
      b0 = beat_q.size();
      ready_tog = 1'b1;
      push_n(16, 64'd200);
      wait_beats(b0 + 16, 300, "s3");
      cycles(4);
      ready_tog = 1'b0;
      chk("s3_nbeats", 64'(beat_q.size() - b0), 64'd16);
      check_burst("s3", b0, 16, 64'd200);
      chk("s3_overflow", 64'(overflow), 64'd0);

      // Ack delayed by 7 cycles.
      b0 = beat_q.size(); l0 = len_q.size();
      r0 = req_hi; q0 = rd_during_req; u0 = len_unstable;
      ack_delay = 7;
      push_n(16, 64'd300);
      wait_beats(b0 + 16, 300, "s4");
      cycles(3);
      ack_delay = 0;
      chk("s4_req_cycles", 64'(req_hi - r0), 64'd8);
      chk("s4_len", 64'(len_q[l0]), 64'd16);
      chk("s4_len_stable", 64'(len_unstable - u0), 64'd0);
      chk("s4_rd_before_ack", 64'(rd_during_req - q0), 64'd0);
      check_burst("s4", b0, 16, 64'd300);

      // Forty words then flush: 16, 16, 8.
      b0 = beat_q.size(); l0 = len_q.size(); fd0 = fd_cnt;
      push_n(40, 64'd400);
      pulse_flush();
      wait_beats(b0 + 40, 500, "s5");
      cycles(5);
      chk("s5_nreq", 64'(len_q.size() - l0), 64'd3);
      chk("s5_len0", 64'(len_q[l0]), 64'd16);
      chk("s5_len1", 64'(len_q[l0 + 1]), 64'd16);
      chk("s5_len2", 64'(len_q[l0 + 2]), 64'd8);
      check_burst("s5a", b0, 16, 64'd400);
      check_burst("s5b", b0 + 16, 16, 64'd416);
      check_burst("s5c", b0 + 32, 8, 64'd432);
      chk("s5_fdone_cnt", 64'(fd_cnt - fd0), 64'd1);
      chk("s5_overflow", 64'(overflow), 64'd0);

      // Reset mid-burst.
      b0 = beat_q.size();
      push_n(16, 64'd500);
      wait_beats(b0 + 6, 200, "s6");
      rst = 1'b1;
      #1;
      chk("s6_in_rst_valid", 64'(dout_valid), 64'd0);
      chk("s6_in_rst_busy", 64'(busy), 64'd0);
      chk("s6_in_rst_rd_en", 64'(fifo_rd_en), 64'd0);
      beats_rst = beat_q.size();
      for (int i = 0; i < 6; i++) chk($sformatf("s6_data%0d", i), beat_q[b0 + i], 64'd500 + 64'(i));
      cycles(1);
      rst = 1'b0;
      issued_rst = issued;
      chk("s6_busy", 64'(busy), 64'd0);
      chk("s6_valid", 64'(dout_valid), 64'd0);
      chk("s6_last", 64'(dout_last), 64'd0);
      chk("s6_req", 64'(burst_req), 64'd0);
      chk("s6_rd_en", 64'(fifo_rd_en), 64'd0);
      cycles(20);
      chk("s6_no_beats", 64'(beat_q.size()), 64'(beats_rst));
      chk("s6_no_reads", 64'(issued), 64'(issued_rst));
      chk("s6_busy_late", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_burst_rd_ctrl.md
FIFO_BURST_RD_CTRL -- requirements
Module: fifo_burst_rd_ctrl

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the FIFO read-side and output data width.
REQ-002 Parameter LVL_W, default 8, SHALL set the width of the FIFO read water level (read depth width + 1).
REQ-003 Parameter BURST_LEN, default 16, SHALL set the full burst length in beats; legal range is 1..2**(LVL_W-1).
REQ-004 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 fifo_rd_en  out  1  SHALL be the FIFO read strobe; data returns one cycle later (no output register).
REQ-007 fifo_rd_data  in  DATA_W  SHALL carry FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 fifo_rd_empty  in  1  SHALL carry the FIFO empty flag.
REQ-009 fifo_rd_water_level  in  LVL_W  SHALL carry the FIFO read-side fill level in words.
REQ-010 flush  in  1  SHALL be a single-cycle request to drain the residue as a short burst.
REQ-011 burst_req  out  1  SHALL request a downstream burst; burst_len  out  LVL_W  SHALL give its beat count.
REQ-012 burst_ack  in  1  SHALL accept the pending burst_req.
REQ-013 dout_data  out  DATA_W, dout_valid  out  1, dout_last  out  1, dout_ready  in  1  SHALL form a valid/ready output stream.
REQ-014 busy  out  1  SHALL be high in any state other than IDLE; flush_done  out  1  SHALL pulse one cycle when a flush completes.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, XFER.
REQ-016 In IDLE, water_level >= BURST_LEN SHALL latch burst_len = BURST_LEN and move to REQ; this check SHALL take priority over flush.
REQ-017 In IDLE, with flush pending and 0 < water_level < BURST_LEN, the FSM SHALL latch burst_len = water_level and move to REQ.
REQ-018 In IDLE, with flush pending and water_level == 0, the FSM SHALL clear flush pending and pulse flush_done next cycle.
REQ-019 flush SHALL set a sticky flush-pending bit; a flush arriving while one is pending SHALL be absorbed.
REQ-020 In REQ, burst_req SHALL be held high with burst_len stable until burst_ack; it SHALL then move to XFER.
REQ-021 burst_ack arriving in the same cycle burst_req first rises SHALL be honoured.
REQ-022 In XFER, fifo_rd_en SHALL assert only when: reads issued < burst_len, !fifo_rd_empty, and skid occupancy + reads in flight < 2.
REQ-023 Returned data SHALL enter a 2-entry skid buffer; dout_valid SHALL be high whenever the buffer is non-empty.
REQ-024 Output data SHALL be presented in FIFO order, with no loss or duplication under any dout_ready pattern.
REQ-025 dout_last SHALL be high on the beat whose index equals burst_len-1.
REQ-026 A handshake on the last beat SHALL return the FSM to IDLE in the next cycle.
REQ-027 The issued-read and accepted-beat counters SHALL be LVL_W wide, clear on entry to XFER, and never wrap within a burst.
REQ-028 Throughput SHALL be 1 beat/cycle when dout_ready is held high and the FIFO is non-empty.

Reset
REQ-029 On rst the FSM SHALL enter IDLE and the skid buffer, counters and flush-pending SHALL clear.
REQ-030 During rst, fifo_rd_en, burst_req, dout_valid, dout_last, busy and flush_done SHALL be 0; burst_len and dout_data SHALL be 0.
REQ-031 rst asserted mid-burst SHALL abort the burst with no further beats; FIFO reset is the integrator's responsibility.

Structure
REQ-032 The FSM state encoding and the skid depth constant (2) SHALL live in the shared package fifo_ctrl_pkg.
REQ-033 The skid buffer SHALL be a separate sub-module, rd_skid_buf (parameter DATA_W; push/pop/count ports).

Verification
REQ-034 Scenario: fill 16 words with values 0..15 and hold dout_ready=1 -> one burst_req with burst_len=16, then 16 consecutive beats 0..15, dout_last on beat 15.
REQ-035 Scenario: fill 5 words, then flush -> burst_len=5, 5 beats, dout_last on the 5th beat, flush_done 1 cycle after IDLE.
REQ-036 Scenario: 16-beat burst with dout_ready toggling 1010... -> data order intact, fifo_rd_en never exceeds skid capacity, 16 beats total.
REQ-037 Scenario: burst_ack delayed 7 cycles -> burst_req and burst_len stable for 8 cycles, no fifo_rd_en before the ack.
REQ-038 Scenario: fill 40 words with flush pending -> bursts of 16, 16, 8 in that order.
REQ-039 Scenario: rst asserted at beat 6 of 16 -> all outputs 0 the next cycle, busy=0, no further beats.
